// File: rtl/shot_responder_if.sv
// rtl/shot_responder_if.sv - placement and shot handshake bundle between the game FSM and shot_responder
// Master is the turn-sequencing FSM, slave is the defending board.
interface shot_responder_if #(
    parameter int RC_W  = 3,
    parameter int CNT_W = 4
) ();
    logic             clear;
    logic             place_en;
    logic [RC_W-1:0]  place_row;
    logic [RC_W-1:0]  place_col;
    logic             place_err;
    logic             shot_req;
    logic [RC_W-1:0]  shot_row;
    logic [RC_W-1:0]  shot_col;
    logic             busy;
    logic             shot_ack;
    logic             shot_hit;
    logic             shot_repeat;
    logic             shot_invalid;
    logic [CNT_W-1:0] cells_left;
    logic             all_sunk;

    modport master (
        output clear, place_en, place_row, place_col,
        output shot_req, shot_row, shot_col,
        input  place_err, busy, shot_ack, shot_hit, shot_repeat, shot_invalid,
        input  cells_left, all_sunk
    );

    modport slave (
        input  clear, place_en, place_row, place_col,
        input  shot_req, shot_row, shot_col,
        output place_err, busy, shot_ack, shot_hit, shot_repeat, shot_invalid,
        output cells_left, all_sunk
    );
endinterface

// File: rtl/shot_responder.sv
// rtl/shot_responder.sv - defending board: ship placement, shot classification, remaining-cell tracking
// Optional SHOT_MAP_EN adds shot_map_o / hit_map_o display ports.
module shot_responder #(
    parameter int ROWS      = 5,
    parameter int COLS      = 5,
    parameter int RC_W      = 3,
    parameter int MAX_CELLS = 10,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    shot_responder_if.slave      bus
`ifdef SHOT_MAP_EN
    ,
    output logic [ROWS*COLS-1:0] shot_map_o,
    output logic [ROWS*COLS-1:0] hit_map_o
`endif
);
    localparam int CELLS = ROWS * COLS;
    localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CELLS-1:0] ship_map_q;
    logic [CELLS-1:0] shot_map_q;
    logic [RC_W-1:0]  tgt_row_q;
    logic [RC_W-1:0]  tgt_col_q;
    logic [CNT_W-1:0] cells_left_q;
    logic [CNT_W-1:0] placed_q;
    logic             locked_q;
    logic             busy_q;
    logic             place_err_q;
    logic             ack_q;
    logic             hit_q;
    logic             repeat_q;
    logic             invalid_q;

    function automatic logic in_range(input logic [RC_W-1:0] r, input logic [RC_W-1:0] c);
        return (32'(r) < 32'(ROWS)) && (32'(c) < 32'(COLS));
    endfunction

    function automatic logic [IDX_W-1:0] cell_idx(input logic [RC_W-1:0] r, input logic [RC_W-1:0] c);
        return IDX_W'(32'(r) * 32'(COLS) + 32'(c));
    endfunction

    logic             place_in_range;
    logic [IDX_W-1:0] place_idx;
    logic             place_ok;
    logic             tgt_in_range;
    logic [IDX_W-1:0] tgt_idx;

    // Map bits are only consulted behind the range check, so a wrapped index is never used.
    assign place_in_range = in_range(bus.place_row, bus.place_col);
    assign place_idx      = cell_idx(bus.place_row, bus.place_col);
    assign place_ok       = !locked_q && place_in_range && !ship_map_q[place_idx]
                            && (32'(placed_q) < 32'(MAX_CELLS));
    assign tgt_in_range   = in_range(tgt_row_q, tgt_col_q);
    assign tgt_idx        = cell_idx(tgt_row_q, tgt_col_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ship_map_q   <= '0;
            shot_map_q   <= '0;
            tgt_row_q    <= '0;
            tgt_col_q    <= '0;
            cells_left_q <= '0;
            placed_q     <= '0;
            locked_q     <= 1'b0;
            busy_q       <= 1'b0;
            place_err_q  <= 1'b0;
            ack_q        <= 1'b0;
            hit_q        <= 1'b0;
            repeat_q     <= 1'b0;
            invalid_q    <= 1'b0;
        end else begin
            place_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.clear) begin
                        ship_map_q   <= '0;
                        shot_map_q   <= '0;
                        cells_left_q <= '0;
                        placed_q     <= '0;
                        locked_q     <= 1'b0;
                    end else if (bus.shot_req) begin
                        tgt_row_q <= bus.shot_row;
                        tgt_col_q <= bus.shot_col;
                        locked_q  <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= CHECK;
                    end else if (bus.place_en) begin
                        if (place_ok) begin
                            ship_map_q[place_idx] <= 1'b1;
                            placed_q              <= placed_q + CNT_W'(1);
                            cells_left_q          <= cells_left_q + CNT_W'(1);
                        end else begin
                            place_err_q <= 1'b1;
                        end
                    end
                end
                CHECK: begin
                    // Flags are registered here so they appear together with ack in UPDATE.
                    place_err_q <= bus.place_en;
                    ack_q       <= 1'b1;
                    invalid_q   <= !tgt_in_range;
                    repeat_q    <= tgt_in_range && shot_map_q[tgt_idx];
                    hit_q       <= tgt_in_range && !shot_map_q[tgt_idx] && ship_map_q[tgt_idx];
                    state_q     <= UPDATE;
                end
                UPDATE: begin
                    place_err_q <= bus.place_en;
                    if (!invalid_q && !repeat_q) begin
                        shot_map_q[tgt_idx] <= 1'b1;
                    end
                    if (hit_q && (cells_left_q != '0)) begin
                        cells_left_q <= cells_left_q - CNT_W'(1);
                    end
                    ack_q     <= 1'b0;
                    hit_q     <= 1'b0;
                    repeat_q  <= 1'b0;
                    invalid_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.place_err    = place_err_q;
    assign bus.busy         = busy_q;
    assign bus.shot_ack     = ack_q;
    assign bus.shot_hit     = hit_q;
    assign bus.shot_repeat  = repeat_q;
    assign bus.shot_invalid = invalid_q;
    assign bus.cells_left   = cells_left_q;
    assign bus.all_sunk     = (cells_left_q == '0) && (placed_q != '0);

`ifdef SHOT_MAP_EN
    assign shot_map_o = shot_map_q;
    assign hit_map_o  = shot_map_q & ship_map_q;
`endif
endmodule

// File: tb/tb_shot_responder.sv
// tb/tb_shot_responder.sv - scoreboard bench for shot_responder, directed plan plus random rounds
module tb_shot_responder;
    localparam int ROWS      = 5;
    localparam int COLS      = 5;
    localparam int RC_W      = 3;
    localparam int MAX_CELLS = 10;
    localparam int CNT_W     = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shot_responder_if #(.RC_W(RC_W), .CNT_W(CNT_W)) bus ();

`ifdef SHOT_MAP_EN
    logic [ROWS*COLS-1:0] shot_map_o;
    logic [ROWS*COLS-1:0] hit_map_o;
`endif

    shot_responder #(
        .ROWS(ROWS), .COLS(COLS), .RC_W(RC_W), .MAX_CELLS(MAX_CELLS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef SHOT_MAP_EN
        ,
        .shot_map_o(shot_map_o),
        .hit_map_o(hit_map_o)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int cyc;
        bit hit;
        bit rep;
        bit inv;
        int left;
        bit sunk;
    } shot_exp_t;

    typedef struct {
        int cyc;
        bit err;
    } place_exp_t;

    shot_exp_t  shot_q[$];
    place_exp_t place_q[$];

    // Reference board: plain 2-D arrays and counts.
    bit m_ship[ROWS][COLS];
    bit m_shot[ROWS][COLS];
    int m_placed;
    int m_left;
    bit m_locked;

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                m_ship[r][c] = 1'b0;
                m_shot[r][c] = 1'b0;
            end
        m_placed = 0;
        m_left   = 0;
        m_locked = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_place(input int r, input int c);
        place_exp_t p;
        bit ok;
        ok = !m_locked && r < ROWS && c < COLS && m_placed < MAX_CELLS;
        if (ok) ok = !m_ship[r][c];
        if (ok) begin
            m_ship[r][c] = 1'b1;
            m_placed++;
            m_left++;
        end
        p.cyc = cyc + 1;
        p.err = !ok;
        place_q.push_back(p);
        bus.place_en  = 1'b1;
        bus.place_row = RC_W'(r);
        bus.place_col = RC_W'(c);
        @(posedge clk); #1;
        bus.place_en = 1'b0;
    endtask

    task automatic do_shot(input int r, input int c);
        shot_exp_t e;
        int n;
        e.hit = 0; e.rep = 0; e.inv = 0;
        if (r >= ROWS || c >= COLS) e.inv = 1;
        else if (m_shot[r][c]) e.rep = 1;
        else begin
            m_shot[r][c] = 1'b1;
            if (m_ship[r][c]) begin
                e.hit = 1;
                if (m_left > 0) m_left--;
            end
        end
        m_locked = 1'b1;
        e.left = m_left;
        e.sunk = (m_left == 0) && (m_placed > 0);
        e.cyc  = cyc + 2;
        shot_q.push_back(e);
        bus.shot_req = 1'b1;
        bus.shot_row = RC_W'(r);
        bus.shot_col = RC_W'(c);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n <= 3) chk("busy", int'(bus.busy), (n >= 2) ? 1 : 0);
        end while (!bus.shot_ack && n < 8);
        if (!bus.shot_ack) begin
            chk("ack_timeout", int'(bus.shot_ack), 1);
            shot_q.delete();
        end
        @(posedge clk); #1;
        bus.shot_req = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        @(posedge clk); #1;
        bus.clear = 1'b0;
        model_clear();
        chk("cells_left_after_clear", int'(bus.cells_left), 0);
        chk("all_sunk_after_clear", int'(bus.all_sunk), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_ack"}, int'(bus.shot_ack), 0);
        chk({tag, "_flags"}, int'({bus.shot_hit, bus.shot_repeat, bus.shot_invalid}), 0);
        chk({tag, "_place_err"}, int'(bus.place_err), 0);
        chk({tag, "_cells_left"}, int'(bus.cells_left), 0);
        chk({tag, "_all_sunk"}, int'(bus.all_sunk), 0);
    endtask

    // Monitor: pops scoreboard entries whenever the DUT presents a result.
    shot_exp_t  mon_e;
    place_exp_t mon_p;
    bit         left_pend = 1'b0;
    int         left_exp;
    bit         sunk_exp;

    always @(negedge clk) begin
        if (!rst) begin
            if (left_pend) begin
                chk("cells_left_after_ack", int'(bus.cells_left), left_exp);
                chk("all_sunk_after_ack", int'(bus.all_sunk), int'(sunk_exp));
                left_pend = 1'b0;
            end
            if (bus.shot_ack) begin
                if (shot_q.size() == 0) begin
                    chk("unexpected_ack", int'(bus.shot_ack), 0);
                end else begin
                    mon_e = shot_q.pop_front();
                    chk("ack_cycle", cyc, mon_e.cyc);
                    chk("shot_hit", int'(bus.shot_hit), int'(mon_e.hit));
                    chk("shot_repeat", int'(bus.shot_repeat), int'(mon_e.rep));
                    chk("shot_invalid", int'(bus.shot_invalid), int'(mon_e.inv));
                    left_exp  = mon_e.left;
                    sunk_exp  = mon_e.sunk;
                    left_pend = 1'b1;
                end
            end else if (bus.shot_hit || bus.shot_repeat || bus.shot_invalid) begin
                chk("flags_without_ack", int'({bus.shot_hit, bus.shot_repeat, bus.shot_invalid}), 0);
            end
            if (place_q.size() > 0 && place_q[0].cyc == cyc) begin
                mon_p = place_q.pop_front();
                chk("place_err", int'(bus.place_err), int'(mon_p.err));
            end else if (bus.place_err) begin
                chk("unexpected_place_err", int'(bus.place_err), 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.clear = 0; bus.place_en = 0; bus.place_row = 0; bus.place_col = 0;
        bus.shot_req = 0; bus.shot_row = 0; bus.shot_col = 0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Placement and duplicate rejection
        do_place(0, 0);
        do_place(0, 1);
        do_place(2, 3);
        chk("cells_left_three", int'(bus.cells_left), 3);
        do_place(0, 0);
        chk("cells_left_after_dup", int'(bus.cells_left), 3);

        // Hit, miss, repeat, invalid
        do_shot(2, 3);
        do_shot(4, 4);
        do_shot(2, 3);
        do_shot(5, 0);
        do_shot(0, 5);

        // Sink the rest, then placement is locked out
        do_shot(0, 0);
        do_shot(0, 1);
        idle(1);
        chk("all_sunk_final", int'(bus.all_sunk), 1);
        do_place(3, 3);
        chk("cells_left_locked", int'(bus.cells_left), 0);

        // Reset while in CHECK aborts the shot
        do_clear();
        do_place(1, 1);
        bus.shot_req = 1'b1; bus.shot_row = 3'd1; bus.shot_col = 3'd1;
        @(posedge clk); #1;
        rst = 1'b1; bus.shot_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        chk_all_zero("rst_abort");
        @(posedge clk); #1;

        // Clear wins over a simultaneous shot request
        do_place(3, 3);
        do_place(4, 4);
        bus.clear = 1'b1; bus.shot_req = 1'b1; bus.shot_row = 3'd3; bus.shot_col = 3'd3;
        @(posedge clk); #1;
        bus.clear = 1'b0; bus.shot_req = 1'b0;
        model_clear();
        idle(3);
        chk("clear_vs_shot_cells_left", int'(bus.cells_left), 0);
        chk("clear_vs_shot_busy", int'(bus.busy), 0);
        do_place(4, 4);
        do_shot(3, 3);

        // Capacity limit
        do_clear();
        for (int i = 0; i <= MAX_CELLS; i++) do_place(i / COLS, i % COLS);
        chk("cells_left_max", int'(bus.cells_left), MAX_CELLS);
        do_shot(1, 2);
`ifdef SHOT_MAP_EN
        chk("shot_map_bit7", int'(shot_map_o[7]), 1);
        chk("hit_map_bit7", int'(hit_map_o[7]), 1);
        chk("hit_map_bit8", int'(hit_map_o[8]), 0);
`endif

        // Random rounds
        for (int round = 0; round < 5; round++) begin
            do_clear();
            for (int i = 0; i < 14; i++) begin
                do_place($urandom_range(0, 6), $urandom_range(0, 6));
                idle($urandom_range(0, 1));
            end
            for (int i = 0; i < 45; i++) begin
                do_shot($urandom_range(0, 5), $urandom_range(0, 6));
                idle($urandom_range(0, 2));
            end
            do_place($urandom_range(0, 4), $urandom_range(0, 4));
        end

        idle(4);
        chk("scoreboard_drained", shot_q.size() + place_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
